// File: rtl/spike_delay_scheduler.sv
// Spike delay scheduler: edge-detects presynaptic spikes, arbitrates them
// round-robin into delay slots and emits one postsynaptic pulse per cycle.
module spike_delay_scheduler #(
    parameter int N_IN   = 4,
    parameter int N_SLOT = 4,
    parameter int DW     = 4,
    localparam int AW    = (N_IN > 1) ? $clog2(N_IN) : 1,
    localparam int SW    = (N_SLOT > 1) ? $clog2(N_SLOT) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_IN-1:0] spike_in,
    input  logic            cfg_we,
    input  logic [AW-1:0]   cfg_addr,
    input  logic [DW-1:0]   cfg_delay,
    output logic            spike_out,
    output logic [AW-1:0]   spike_src,
    output logic            drop,
    output logic            busy
);

    logic [N_IN-1:0]   prev_q;
    logic [N_IN-1:0]   pend_q, pend_d;
    logic [N_IN-1:0]   ev, grant;
    logic [AW-1:0]     ptr_q, ptr_d;
    logic [DW-1:0]     dly_q [N_IN];
    logic [N_SLOT-1:0] val_q;
    logic [DW-1:0]     cnt_q [N_SLOT];
    logic [AW-1:0]     src_q [N_SLOT];
    logic              out_q, drop_q;
    logic [AW-1:0]     osrc_q;

    logic              free_ok, gnt_ok, gnt, em_ok;
    logic [SW-1:0]     free_idx, em_idx;
    logic [AW-1:0]     gnt_idx, idx;

    assign ev = spike_in & ~prev_q;

    always_comb begin
        free_ok  = 1'b0;
        free_idx = '0;
        em_ok    = 1'b0;
        em_idx   = '0;
        gnt_ok   = 1'b0;
        gnt_idx  = '0;
        idx      = '0;
        // Descending scans so the lowest index / nearest-to-pointer wins.
        for (int s = N_SLOT - 1; s >= 0; s--) begin
            if (!val_q[s]) begin
                free_ok  = 1'b1;
                free_idx = SW'(s);
            end
            if (val_q[s] && cnt_q[s] == '0) begin
                em_ok  = 1'b1;
                em_idx = SW'(s);
            end
        end
        for (int j = N_IN - 1; j >= 0; j--) begin
            idx = ptr_q + AW'(j);
            if (pend_q[idx]) begin
                gnt_ok  = 1'b1;
                gnt_idx = idx;
            end
        end
        gnt    = gnt_ok && free_ok;
        grant  = gnt ? (N_IN'(1) << gnt_idx) : '0;
        ptr_d  = gnt ? gnt_idx + AW'(1) : ptr_q;
        pend_d = (pend_q & ~grant) | ev;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_q <= '1;
            pend_q <= '0;
            ptr_q  <= '0;
            val_q  <= '0;
            out_q  <= 1'b0;
            osrc_q <= '0;
            drop_q <= 1'b0;
            for (int i = 0; i < N_IN; i++) dly_q[i] <= DW'(1);
            for (int s = 0; s < N_SLOT; s++) begin
                cnt_q[s] <= '0;
                src_q[s] <= '0;
            end
        end else begin
            prev_q <= spike_in;
            pend_q <= pend_d;
            ptr_q  <= ptr_d;
            drop_q <= |(ev & pend_q & ~grant);
            out_q  <= em_ok;
            osrc_q <= em_ok ? src_q[em_idx] : '0;
            if (cfg_we) dly_q[cfg_addr] <= cfg_delay;
            for (int s = 0; s < N_SLOT; s++) begin
                if (em_ok && em_idx == SW'(s))
                    val_q[s] <= 1'b0;
                else if (val_q[s] && cnt_q[s] != '0)
                    cnt_q[s] <= cnt_q[s] - DW'(1);
            end
            // Grant targets a slot that is not valid, so it never collides
            // with the emit/decrement updates above.
            if (gnt) begin
                val_q[free_idx] <= 1'b1;
                src_q[free_idx] <= gnt_idx;
                cnt_q[free_idx] <= dly_q[gnt_idx];
            end
        end
    end

    assign spike_out = out_q;
    assign spike_src = osrc_q;
    assign drop      = drop_q;
    assign busy      = (|pend_q) | (|val_q);

endmodule

// File: tb/tb_spike_delay_scheduler.sv
// Directed bench for spike_delay_scheduler: latency, arbitration,
// slot exhaustion, config timing and reset behaviour.
module tb_spike_delay_scheduler;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] spike_in = '0;
    logic       cfg_we = 1'b0;
    logic [1:0] cfg_addr = '0;
    logic [3:0] cfg_delay = '0;
    logic       spike_out;
    logic [1:0] spike_src;
    logic       drop;
    logic       busy;

    int total = 0;
    int bad = 0;

    spike_delay_scheduler dut (
        .clk(clk), .rst_n(rst_n), .spike_in(spike_in),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_delay(cfg_delay),
        .spike_out(spike_out), .spike_src(spike_src),
        .drop(drop), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        spike_in = '0;
        cfg_we = 1'b0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic wr(input logic [1:0] a, input logic [3:0] d);
        cfg_we = 1'b1;
        cfg_addr = a;
        cfg_delay = d;
        step();
        cfg_we = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        spike_in = 4'b1111;
        step();
        total++;
        if ({spike_out, spike_src, drop, busy} !== 5'b0) begin
            bad++;
            $display("FAIL reset_outputs got=%b want=00000",
                     {spike_out, spike_src, drop, busy});
        end
        rst_n = 1'b1;
        step();
        step();
        total++;
        if (busy !== 1'b0 || spike_out !== 1'b0) begin
            bad++;
            $display("FAIL reset_high_level busy=%b out=%b want 0 0",
                     busy, spike_out);
        end
        do_reset();
    endtask

    task automatic test_single();
        logic eo;
        do_reset();
        wr(2'd2, 4'd5);
        spike_in = 4'b0100;
        step();
        for (int n = 1; n <= 8; n++) begin
            step();
            eo = (n == 7);
            total++;
            if (spike_out !== eo || spike_src !== (eo ? 2'd2 : 2'd0)) begin
                bad++;
                $display("FAIL single n=%0d out=%b src=%0d want %b %0d",
                         n, spike_out, spike_src, eo, eo ? 2 : 0);
            end
            if (n == 3 || n == 8) begin
                total++;
                if (busy !== (n == 3)) begin
                    bad++;
                    $display("FAIL single_busy n=%0d got=%b want=%b",
                             n, busy, n == 3);
                end
            end
        end
    endtask

    task automatic test_all_zero();
        logic eo;
        do_reset();
        for (int i = 0; i < 4; i++) wr(2'(i), 4'd0);
        spike_in = 4'b1111;
        step();
        for (int n = 1; n <= 6; n++) begin
            step();
            eo = (n >= 2 && n <= 5);
            total++;
            if (spike_out !== eo || drop !== 1'b0 ||
                spike_src !== (eo ? 2'(n - 2) : 2'd0)) begin
                bad++;
                $display("FAIL zero n=%0d out=%b src=%0d drop=%b want %b %0d 0",
                         n, spike_out, spike_src, drop, eo, eo ? n - 2 : 0);
            end
        end
    endtask

    task automatic test_full();
        logic       eo;
        logic [1:0] es;
        do_reset();
        for (int i = 0; i < 4; i++) wr(2'(i), 4'd15);
        spike_in = 4'b1111;
        step();
        for (int n = 1; n <= 4; n++) step();
        spike_in = 4'b1110;
        step();
        spike_in = 4'b1111;
        step();
        total++;
        if (drop !== 1'b0) begin
            bad++;
            $display("FAIL full_second_event drop=%b want=0", drop);
        end
        spike_in = 4'b1110;
        step();
        spike_in = 4'b1111;
        step();
        total++;
        if (drop !== 1'b1) begin
            bad++;
            $display("FAIL full_third_event drop=%b want=1", drop);
        end
        for (int n = 9; n <= 35; n++) begin
            step();
            eo = (n >= 17 && n <= 20) || n == 34;
            es = (n >= 17 && n <= 20) ? 2'(n - 17) : 2'd0;
            total++;
            if (spike_out !== eo || spike_src !== es || drop !== 1'b0) begin
                bad++;
                $display("FAIL full n=%0d out=%b src=%0d drop=%b want %b %0d 0",
                         n, spike_out, spike_src, drop, eo, es);
            end
            if (n == 21 || n == 35) begin
                total++;
                if (busy !== (n == 21)) begin
                    bad++;
                    $display("FAIL full_busy n=%0d got=%b want=%b",
                             n, busy, n == 21);
                end
            end
        end
    endtask

    task automatic test_cfg_inflight();
        logic eo;
        do_reset();
        wr(2'd1, 4'd3);
        spike_in = 4'b0010;
        step();
        step();
        cfg_we = 1'b1;
        cfg_addr = 2'd1;
        cfg_delay = 4'd9;
        step();
        cfg_we = 1'b0;
        for (int n = 3; n <= 6; n++) begin
            step();
            eo = (n == 5);
            total++;
            if (spike_out !== eo || spike_src !== (eo ? 2'd1 : 2'd0)) begin
                bad++;
                $display("FAIL cfg_old n=%0d out=%b src=%0d want %b",
                         n, spike_out, spike_src, eo);
            end
        end
        spike_in = 4'b0000;
        step();
        spike_in = 4'b0010;
        step();
        for (int n = 1; n <= 12; n++) begin
            step();
            eo = (n == 11);
            total++;
            if (spike_out !== eo || spike_src !== (eo ? 2'd1 : 2'd0)) begin
                bad++;
                $display("FAIL cfg_new n=%0d out=%b src=%0d want %b",
                         n, spike_out, spike_src, eo);
            end
        end
    endtask

    task automatic test_mid_reset();
        logic eo;
        do_reset();
        wr(2'd0, 4'd10);
        wr(2'd1, 4'd10);
        spike_in = 4'b0011;
        step();
        step();
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int n = 1; n <= 15; n++) begin
            step();
            total++;
            if (spike_out !== 1'b0 || drop !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL mid_reset n=%0d out=%b drop=%b busy=%b want 0 0 0",
                         n, spike_out, drop, busy);
            end
        end
        spike_in = 4'b0000;
        step();
        spike_in = 4'b0001;
        step();
        for (int n = 1; n <= 4; n++) begin
            step();
            eo = (n == 3);
            total++;
            if (spike_out !== eo || spike_src !== 2'd0) begin
                bad++;
                $display("FAIL default_delay n=%0d out=%b src=%0d want %b 0",
                         n, spike_out, spike_src, eo);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic       eo;
        logic [1:0] es;
        do_reset();
        wr(2'd0, 4'd3);
        wr(2'd1, 4'd2);
        spike_in = 4'b0011;
        step();
        for (int n = 1; n <= 7; n++) begin
            step();
            eo = (n == 5 || n == 6);
            es = (n == 6) ? 2'd1 : 2'd0;
            total++;
            if (spike_out !== eo || spike_src !== es) begin
                bad++;
                $display("FAIL same_zero n=%0d out=%b src=%0d want %b %0d",
                         n, spike_out, spike_src, eo, es);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_zero();
        test_full();
        test_cfg_inflight();
        test_mid_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spike_delay_scheduler.md
SPIKE_DELAY_SCHEDULER -- requirements
Module: spike_delay_scheduler

Interface
REQ-001 SHALL have parameter N_IN, default 4, number of presynaptic spike inputs (power of 2, 2..8).
REQ-002 SHALL have parameter N_SLOT, default 4, number of in-flight delay slots.
REQ-003 SHALL have parameter DW, default 4, width of delay values in cycles.
REQ-004 SHALL have port clk  input  1  single system clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  synchronous active-low reset, sampled on clk rising edge.
REQ-006 SHALL have port spike_in  input  N_IN  presynaptic spike levels; a 0->1 transition is one spike event.
REQ-007 SHALL have port cfg_we  input  1  write strobe for the per-input delay table.
REQ-008 SHALL have port cfg_addr  input  log2(N_IN)  delay table index.
REQ-009 SHALL have port cfg_delay  input  DW  delay value to write.
REQ-010 SHALL have port spike_out  output  1  one-cycle postsynaptic spike pulse.
REQ-011 SHALL have port spike_src  output  log2(N_IN)  input index of the spike on spike_out; 0 when spike_out=0.
REQ-012 SHALL have port drop  output  1  one-cycle pulse when a spike event is lost.
REQ-013 SHALL have port busy  output  1  high while any pending bit or valid slot exists.

Function
REQ-014 SHALL detect a spike event on input i when spike_in[i]=1 at edge k and spike_in[i]=0 at edge k-1.
REQ-015 SHALL hold one pending bit per input, set at the edge a spike event is detected.
REQ-016 SHALL, if an event arrives on input i whose pending bit is still set and not granted that cycle, discard it and pulse drop.
REQ-017 SHALL grant at most one pending input per cycle, round-robin, starting from the input after the last granted one.
REQ-018 SHALL grant only when a free slot exists; the grant clears the pending bit and loads the lowest-index free slot with valid=1, src=i, cnt=delay[i].
REQ-019 SHALL, when no slot is free, keep pending bits and freeze the round-robin pointer (no drop from slot exhaustion alone).
REQ-020 SHALL decrement cnt of every valid slot with cnt>0 each cycle and hold cnt at 0 (no wrap).
REQ-021 SHALL, among valid slots with cnt=0, emit the lowest-index one: spike_out=1, spike_src=src for one cycle, slot freed at that edge.
REQ-022 SHALL keep unemitted cnt=0 slots valid and emit them on subsequent cycles in index order.
REQ-023 SHALL make a slot freed at edge k available for a grant at edge k+1, not edge k.
REQ-024 SHALL register spike_out, spike_src, drop; with no contention, an event detected at edge k produces spike_out high after edge k+2+D, D=delay[src].
REQ-025 SHALL treat D=0 as minimum latency (spike_out high after edge k+2).
REQ-026 SHALL write delay[cfg_addr]=cfg_delay on an edge with cfg_we=1; in-flight slots keep their loaded cnt; a grant on the same edge uses the old value.
REQ-027 SHALL derive busy combinationally from pending bits and slot valid bits.

Reset
REQ-028 SHALL, on an edge with rst_n=0, clear all pending bits, slot valid bits, cnt and src fields, set spike_out=0, spike_src=0, drop=0, round-robin pointer to input 0.
REQ-029 SHALL set every delay table entry to 1 on reset.
REQ-030 SHALL set the previous-sample register of spike_in to all-ones on reset so a level already high at reset release creates no event.
REQ-031 SHALL discard in-flight spikes when reset is asserted mid-operation; no spike_out after reset deasserts unless new events occur.

Verification
REQ-032 Bench: write delay[2]=5, rising edge on spike_in[2] detected at edge 10 -> single spike_out pulse after edge 17, spike_src=2, busy low after edge 18.
REQ-033 Bench: all delays 0, spike_in 0000->1111 at edge k -> spike_out on four consecutive cycles after edges k+2..k+5, src order 0,1,2,3; no drop.
REQ-034 Bench: N_SLOT=4, delays 15, events on inputs 0-3 then a second event on input 0 while slots full -> input 0 stays pending (no drop); a third event on input 0 before grant -> drop pulses once.
REQ-035 Bench: delay[1]=3, event on input 1, cfg write delay[1]=9 two cycles later -> spike still emitted at original latency (k+5); next event uses 9.
REQ-036 Bench: rst_n low for one cycle while two slots valid and spike_in held high -> no spike_out, drop=0, busy=0 afterwards until a fresh 0->1 transition.
REQ-037 Bench: two slots reaching cnt=0 same cycle -> lower-index slot emits first, other emits next cycle.
